window_scan_ctrl: RTL and testbench

WINDOW_SCAN_CTRL -- requirements
Module: window_scan_ctrl

---
 rtl/window_scan_ctrl.sv | 153 +++++++++++++++
 tb/tb_window_scan_ctrl.sv | 308 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/window_scan_ctrl.sv
// rtl/window_scan_ctrl.sv - 3x3 window address generator for a square image scan
//
// Walks the top-left corner of a 3x3 window over every interior position of
// an IMG_SIZE x IMG_SIZE image, row-major. Each accepted window (win_valid &&
// win_ready) advances to the next position; the frame ends with a one-cycle
// done pulse.
//
// Optional feature: define WINDOW_SCAN_ABORT_EN to add the abort input.
//
// Ports:
//   clk        - rising-edge clock
//   rst_n      - asynchronous active-low reset
//   start      - one-cycle request to begin a frame scan (honoured in IDLE only)
//   busy       - scan in progress
//   done       - one-cycle pulse at frame completion
//   im_addr    - top-left pixel address of the current window (image RAM)
//   win_valid  - im_addr/out_addr hold a valid window position
//   win_ready  - downstream datapath accepts the current window
//   abort      - (WINDOW_SCAN_ABORT_EN only) drop the current scan, back to IDLE
//   out_addr   - linear result index, row*(IMG_SIZE-2)+col

module window_scan_ctrl #(
    parameter int IMG_SIZE = 10,
    parameter int ADDR_W   = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-1:0] im_addr,
    output logic              win_valid,
    input  logic              win_ready,
`ifdef WINDOW_SCAN_ABORT_EN
    input  logic              abort,
`endif
    output logic [ADDR_W-1:0] out_addr
);

    // Index of the last legal window row/column.
    localparam logic [7:0] LAST_IDX = 8'(IMG_SIZE - 3);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_SCAN = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t     state;
    state_t     state_next;
    logic [7:0] row;
    logic [7:0] col;
    logic       abort_hit;
    logic       hs;
    logic       col_last;
    logic       row_last;

`ifdef WINDOW_SCAN_ABORT_EN
    assign abort_hit = (state == S_SCAN) && abort;
`else
    assign abort_hit = 1'b0;
`endif

    // Abort takes priority over an accepted window: nothing advances.
    assign hs       = (state == S_SCAN) && win_ready && !abort_hit;
    assign col_last = (col == LAST_IDX);
    assign row_last = (row == LAST_IDX);

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic
    always_comb begin
        state_next = state;
        case (state)
            S_IDLE: begin
                if (start) begin
                    state_next = S_SCAN;
                end
            end
            S_SCAN: begin
                if (abort_hit) begin
                    state_next = S_IDLE;
                end else if (hs && col_last && row_last) begin
                    state_next = S_DONE;
                end
            end
            S_DONE: begin
                state_next = S_IDLE;
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    // Outputs decode straight from the state register so reset clears them
    // without waiting for a clock edge.
    always_comb begin
        busy      = 1'b0;
        win_valid = 1'b0;
        done      = 1'b0;
        case (state)
            S_SCAN: begin
                busy      = 1'b1;
                win_valid = 1'b1;
            end
            S_DONE: begin
                done = 1'b1;
            end
            default: begin
                busy      = 1'b0;
                win_valid = 1'b0;
                done      = 1'b0;
            end
        endcase
    end

    // Window position counters. Addresses keep their final value through
    // DONE and IDLE until the next accepted start.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            row      <= '0;
            col      <= '0;
            im_addr  <= '0;
            out_addr <= '0;
        end else if ((state == S_IDLE) && start) begin
            row      <= '0;
            col      <= '0;
            im_addr  <= '0;
            out_addr <= '0;
        end else if (hs) begin
            if (!col_last) begin
                col      <= col + 8'd1;
                im_addr  <= im_addr + ADDR_W'(1);
                out_addr <= out_addr + ADDR_W'(1);
            end else if (!row_last) begin
                // Wrap to the next row: step over the two border columns.
                col      <= '0;
                row      <= row + 8'd1;
                im_addr  <= im_addr + ADDR_W'(3);
                out_addr <= out_addr + ADDR_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_window_scan_ctrl.sv
// tb/tb_window_scan_ctrl.sv - scoreboard bench for window_scan_ctrl

module tb_window_scan_ctrl;

    localparam int N  = 10;
    localparam int AW = 16;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          start;
    logic          busy;
    logic          done;
    logic [AW-1:0] im_addr;
    logic          win_valid;
    logic          win_ready;
    logic          abort;
    logic [AW-1:0] out_addr;

    logic          start3;
    logic          busy3;
    logic          done3;
    logic [AW-1:0] im3;
    logic          wv3;
    logic [AW-1:0] out3;

    always #5 clk = ~clk;

    window_scan_ctrl #(.IMG_SIZE(N), .ADDR_W(AW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .busy      (busy),
        .done      (done),
        .im_addr   (im_addr),
        .win_valid (win_valid),
        .win_ready (win_ready),
`ifdef WINDOW_SCAN_ABORT_EN
        .abort     (abort),
`endif
        .out_addr  (out_addr)
    );

    window_scan_ctrl #(.IMG_SIZE(3), .ADDR_W(AW)) dut3 (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start3),
        .busy      (busy3),
        .done      (done3),
        .im_addr   (im3),
        .win_valid (wv3),
        .win_ready (1'b1),
`ifdef WINDOW_SCAN_ABORT_EN
        .abort     (1'b0),
`endif
        .out_addr  (out3)
    );

    typedef struct packed {
        logic [AW-1:0] im;
        logic [AW-1:0] out;
    } win_t;

    win_t exp_q[$];
    int   exp_done_q[$];
    int   checks   = 0;
    int   failures = 0;
    int   hs_cnt   = 0;
    int   done_cnt = 0;
    bit   rnd_ready = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Reference model: every interior window of an n x n image, row-major.
    task automatic push_frame(input int n);
        win_t w;
        for (int r = 0; r <= n - 3; r++) begin
            for (int c = 0; c <= n - 3; c++) begin
                w.im  = AW'(r * n + c);
                w.out = AW'(r * (n - 2) + c);
                exp_q.push_back(w);
            end
        end
        exp_done_q.push_back((n - 2) * (n - 2));
    endtask

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        cycle();
        start = 1'b0;
    endtask

    task automatic wait_hs(input int target);
        int k;
        k = 0;
        while (hs_cnt < target && k < 3000) begin
            cycle();
            k++;
        end
        chk("handshake_reached", 32'(hs_cnt >= target), 1);
    endtask

    task automatic wait_done(input int prev);
        int k;
        k = 0;
        while (done_cnt <= prev && k < 3000) begin
            cycle();
            k++;
        end
        chk("done_arrived", 32'(done_cnt > prev), 1);
    endtask

    // win_ready driver: constant 1 or pseudo-random per cycle.
    initial begin
        win_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            win_ready = rnd_ready ? 1'($urandom % 2) : 1'b1;
        end
    end

    // Monitor: compares presented windows against the scoreboard, checks
    // stalls hold, and checks done behaviour.
    bit            stall_pend = 1'b0;
    logic [AW-1:0] st_im;
    logic [AW-1:0] st_out;
    bit            prev_done  = 1'b0;
    int            frame_hs   = 0;

    always @(negedge clk) begin
        bit   hs_now;
        win_t e;
        if (!rst_n) begin
            stall_pend = 1'b0;
            prev_done  = 1'b0;
        end else begin
            if (start && !busy && !done) frame_hs = 0;
            chk("busy_eq_valid", 32'(busy), 32'(win_valid));
            if (stall_pend) begin
                chk("stall_hold_im", 32'(im_addr), 32'(st_im));
                chk("stall_hold_out", 32'(out_addr), 32'(st_out));
            end
            hs_now = win_valid && win_ready && !abort;
            if (win_valid && !hs_now) begin
                stall_pend = 1'b1;
                st_im      = im_addr;
                st_out     = out_addr;
            end else begin
                stall_pend = 1'b0;
            end
            if (hs_now) begin
                chk("window_expected", 32'(exp_q.size() > 0), 1);
                if (exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                    chk("im_addr", 32'(im_addr), 32'(e.im));
                    chk("out_addr", 32'(out_addr), 32'(e.out));
                end
                hs_cnt++;
                frame_hs++;
            end
            if (done) begin
                done_cnt++;
                chk("done_expected", 32'(exp_done_q.size() > 0), 1);
                if (exp_done_q.size() > 0)
                    chk("frame_handshakes", 32'(frame_hs), 32'(exp_done_q.pop_front()));
                chk("done_busy_low", 32'(busy), 0);
                chk("done_valid_low", 32'(win_valid), 0);
            end
            if (prev_done) chk("done_one_cycle", 32'(done), 0);
            prev_done = done;
        end
    end

    initial begin
        int base;
        int d0;
        int hs3;
        int d3;
        int k;
        rst_n  = 1'b0;
        start  = 1'b0;
        start3 = 1'b0;
        abort  = 1'b0;
        #3;
        chk("rst_busy", 32'(busy), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_valid", 32'(win_valid), 0);
        chk("rst_im", 32'(im_addr), 0);
        chk("rst_out", 32'(out_addr), 0);
        cycle();
        cycle();
        rst_n = 1'b1;
        repeat (3) cycle();
        chk("idle_after_reset", 32'(busy), 0);

        // Frame 1: win_ready held high.
        rnd_ready = 1'b0;
        push_frame(N);
        d0 = done_cnt;
        pulse_start();
        chk("busy_after_start", 32'(busy), 1);
        wait_done(d0);
        repeat (2) cycle();
        chk("f1_idle", 32'(busy), 0);
        chk("f1_final_im", 32'(im_addr), 32'((N - 3) * (N + 1)));
        chk("f1_final_out", 32'(out_addr), 32'((N - 2) * (N - 2) - 1));
        chk("f1_queue_empty", 32'(exp_q.size()), 0);

        // Frame 2: random win_ready, extra start at handshake 10 is ignored.
        rnd_ready = 1'b1;
        push_frame(N);
        d0 = done_cnt;
        base = hs_cnt;
        pulse_start();
        wait_hs(base + 10);
        pulse_start();
        wait_done(d0);
        repeat (20) cycle();
        chk("f2_single_done", 32'(done_cnt - d0), 1);
        chk("f2_queue_empty", 32'(exp_q.size()), 0);
        chk("f2_idle", 32'(busy), 0);

        // Frame 3: asynchronous reset at handshake 20, then a clean rescan.
        push_frame(N);
        d0 = done_cnt;
        base = hs_cnt;
        pulse_start();
        wait_hs(base + 20);
        #2;
        rst_n = 1'b0;
        exp_q.delete();
        exp_done_q.delete();
        #1;
        chk("mid_rst_busy", 32'(busy), 0);
        chk("mid_rst_valid", 32'(win_valid), 0);
        chk("mid_rst_im", 32'(im_addr), 0);
        chk("mid_rst_out", 32'(out_addr), 0);
        cycle();
        rst_n = 1'b1;
        repeat (5) cycle();
        chk("mid_rst_no_done", 32'(done_cnt), 32'(d0));
        chk("mid_rst_idle", 32'(busy), 0);
        push_frame(N);
        pulse_start();
        wait_done(d0);
        repeat (2) cycle();
        chk("f3_queue_empty", 32'(exp_q.size()), 0);

`ifdef WINDOW_SCAN_ABORT_EN
        rnd_ready = 1'b0;
        push_frame(N);
        d0 = done_cnt;
        pulse_start();
        k = 0;
        while (im_addr != AW'(15) && k < 200) begin
            cycle();
            k++;
        end
        chk("abort_pos_reached", 32'(im_addr), 15);
        abort = 1'b1;
        cycle();
        abort = 1'b0;
        exp_q.delete();
        exp_done_q.delete();
        chk("abort_busy", 32'(busy), 0);
        chk("abort_valid", 32'(win_valid), 0);
        chk("abort_im_hold", 32'(im_addr), 15);
        chk("abort_out_hold", 32'(out_addr), 13);
        repeat (3) cycle();
        chk("abort_no_done", 32'(done_cnt), 32'(d0));
`endif

        // Smallest image: exactly one window, then done.
        rnd_ready = 1'b0;
        hs3 = 0;
        d3  = 0;
        start3 = 1'b1;
        cycle();
        start3 = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (wv3) begin
                chk("s3_im", 32'(im3), 0);
                chk("s3_out", 32'(out3), 0);
                hs3++;
            end
            if (done3) d3++;
        end
        chk("s3_handshakes", 32'(hs3), 1);
        chk("s3_done_pulses", 32'(d3), 1);
        chk("s3_idle", 32'(busy3), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
